pcm_rom_fetch: RTL

//  Memory-side responder for the PCM sample ROM port of the jt6295 path.

---
 rtl/pcm_rom_fetch.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pcm_rom_fetch.sv
// PCM sample ROM responder: serves jt6295 byte reads from an 8-byte line buffer
// and refills that line with one 4-word SDRAM burst whenever the address misses.
module pcm_rom_fetch #(
  parameter logic [24:0] BASE_ADDR   = 25'h0E8000,
  parameter int          BURST_WORDS = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [17:0] pcm_rom_addr,
  input  logic        pcm_rom_read,
  output logic [7:0]  pcm_rom_data,
  output logic        pcm_rom_data_rdy,
  output logic        sd_req,
  output logic [24:0] sd_addr,
  input  logic        sd_ack,
  input  logic        sd_valid,
  input  logic [15:0] sd_data
);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  localparam logic [1:0] LAST_WORD = 2'(BURST_WORDS - 1);

  state_t      state_reg, state_next;
  logic [17:0] addr_q_reg;
  logic [14:0] tag_reg;
  logic [14:0] fill_tag_reg;
  logic        line_valid_reg;
  logic [1:0]  cnt_reg;
  logic [24:0] sd_addr_reg;
  logic [7:0]  data_reg;
  logic        rdy_reg;
  logic [7:0]  buf_mem [8];

  logic        hit;
  logic        addr_changed;
  logic        word_wr;
  logic        last_word;
  logic [1:0]  word_idx;
  logic        unused_read;

  // Misses are detected from the address itself; the read level carries no extra information.
  assign unused_read  = pcm_rom_read;
  assign hit          = line_valid_reg && (tag_reg == pcm_rom_addr[17:3]);
  assign addr_changed = (pcm_rom_addr != addr_q_reg);
  // An ack arriving together with the first strobe makes that strobe word 0.
  assign word_wr      = sd_valid && ((state_reg == FILL) || ((state_reg == REQ) && sd_ack));
  assign word_idx     = (state_reg == FILL) ? cnt_reg : 2'd0;
  assign last_word    = (state_reg == FILL) && sd_valid && (cnt_reg == LAST_WORD);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (!hit) state_next = REQ;
      REQ:     if (sd_ack) state_next = FILL;
      FILL:    if (last_word) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sd_req           = (state_reg == REQ);
    sd_addr          = sd_addr_reg;
    pcm_rom_data     = data_reg;
    pcm_rom_data_rdy = rdy_reg;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      addr_q_reg     <= '0;
      tag_reg        <= '0;
      fill_tag_reg   <= '0;
      line_valid_reg <= 1'b0;
      cnt_reg        <= '0;
      sd_addr_reg    <= '0;
      data_reg       <= '0;
      rdy_reg        <= 1'b0;
    end else begin
      addr_q_reg <= pcm_rom_addr;
      rdy_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hit) begin
            data_reg <= buf_mem[pcm_rom_addr[2:0]];
            rdy_reg  <= !addr_changed;
          end else begin
            fill_tag_reg <= pcm_rom_addr[17:3];
            sd_addr_reg  <= BASE_ADDR + {7'd0, pcm_rom_addr[17:3], 3'd0};
          end
        end
        REQ: begin
          if (sd_ack) cnt_reg <= sd_valid ? 2'd1 : 2'd0;
        end
        FILL: begin
          if (sd_valid) begin
            cnt_reg <= cnt_reg + 2'd1;
            if (last_word) begin
              tag_reg        <= fill_tag_reg;
              line_valid_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (word_wr) begin
      buf_mem[{word_idx, 1'b0}] <= sd_data[7:0];
      buf_mem[{word_idx, 1'b1}] <= sd_data[15:8];
    end
  end

endmodule
